// File: rtl/mlkem_rand_pkg.sv
// Shared constants and state encoding for ML-KEM masking-randomness distribution.
package mlkem_rand_pkg;
    localparam int RAND_W        = 16;
    localparam int DEF_WARMUP    = 64;
    localparam int DEF_BURST_LEN = 16;

    typedef logic [1:0] state_t;
    localparam state_t S_WARM  = 2'd0;
    localparam state_t S_ARB   = 2'd1;
    localparam state_t S_SERVE = 2'd2;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set req bit at or after ptr, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_next,
    output logic [$clog2(N)-1:0] index,
    output logic                 any
);
    localparam int PW = $clog2(N);

    always_comb begin
        gnt_next = '0;
        index    = '0;
        any      = 1'b0;
        // Scan from the farthest offset down so the nearest requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt_next                      = '0;
                gnt_next[(int'(ptr) + k) % N] = 1'b1;
                index                         = PW'((int'(ptr) + k) % N);
                any                           = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rand_sched.sv
// Hands the free-running randomness stream to one requester at a time after a
// post-reset warm-up; round-robin fair, bounded bursts, every word used once.
module rand_sched
    import mlkem_rand_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WARMUP    = DEF_WARMUP,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RAND_W-1:0] rand_in,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [RAND_W-1:0] rand_out,
    output logic              rand_valid,
    output logic              ready
);
    localparam int WW = $clog2(WARMUP + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int PW = $clog2(N_REQ);

    state_t             r_state;
    logic [WW-1:0]      r_warm;
    logic [BW-1:0]      r_burst;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_idx;
    logic [N_REQ-1:0]   r_gnt;
    logic [RAND_W-1:0]  r_out;
    logic               r_valid;
    logic               r_ready;

    logic [N_REQ-1:0]   w_gnt_next;
    logic [PW-1:0]      w_idx;
    logic               w_any;
    logic [PW-1:0]      w_ptr_next;

    rr_pick #(.N(N_REQ)) u_pick (
        .req      (req),
        .ptr      (r_ptr),
        .gnt_next (w_gnt_next),
        .index    (w_idx),
        .any      (w_any)
    );

    assign w_ptr_next = (r_idx == PW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_WARM;
            r_warm  <= '0;
            r_burst <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_gnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_WARM: begin
                    r_warm <= r_warm + 1'b1;
                    if (r_warm == WW'(WARMUP - 1)) begin
                        r_state <= S_ARB;
                        r_ready <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (w_any) begin
                        r_gnt   <= w_gnt_next;
                        r_idx   <= w_idx;
                        r_out   <= rand_in;
                        r_valid <= 1'b1;
                        r_burst <= BW'(1);
                        r_state <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (req[r_idx] && (r_burst < BW'(BURST_LEN))) begin
                        r_out   <= rand_in;
                        r_valid <= 1'b1;
                        r_burst <= r_burst + 1'b1;
                    end else begin
                        // Release costs one idle cycle before the next arbitration.
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                        r_ptr   <= w_ptr_next;
                        r_state <= S_ARB;
                    end
                end
                default: r_state <= S_WARM;
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign rand_out   = r_out;
    assign rand_valid = r_valid;
    assign ready      = r_ready;
endmodule

// File: tb/tb_rand_sched.sv
// Directed bench for rand_sched: three instances cover the default warm-up,
// long bursts with reset/pulse cases, and short bursts with strict rotation.
module tb_rand_sched;
    localparam int STARVE = (4 - 1) * (16 + 1);

    logic        clk = 1'b0;
    logic [15:0] rand_in;
    logic [15:0] prev_in;
    logic        rst_a, rst_b, rst_c;
    logic [3:0]  req_a, req_b, req_c;
    logic [3:0]  gnt_a, gnt_b, gnt_c;
    logic [15:0] rout_a, rout_b, rout_c;
    logic        vld_a, vld_b, vld_c;
    logic        rdy_a, rdy_b, rdy_c;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] last_del [3];
    int          wt [4];
    logic [3:0]  rot [13];
    logic [3:0]  nreq;

    always #5 clk = ~clk;

    rand_sched #(.N_REQ(4), .WARMUP(64), .BURST_LEN(16)) u_a (
        .clk(clk), .rst(rst_a), .rand_in(rand_in), .req(req_a), .gnt(gnt_a),
        .rand_out(rout_a), .rand_valid(vld_a), .ready(rdy_a));
    rand_sched #(.N_REQ(4), .WARMUP(4), .BURST_LEN(16)) u_b (
        .clk(clk), .rst(rst_b), .rand_in(rand_in), .req(req_b), .gnt(gnt_b),
        .rand_out(rout_b), .rand_valid(vld_b), .ready(rdy_b));
    rand_sched #(.N_REQ(4), .WARMUP(4), .BURST_LEN(2)) u_c (
        .clk(clk), .rst(rst_c), .rand_in(rand_in), .req(req_c), .gnt(gnt_c),
        .rand_out(rout_c), .rand_valid(vld_c), .ready(rdy_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected data is the generator word that was on rand_in during the cycle before.
    task automatic chk_word(input string tag, input int id, input logic [3:0] g, input logic v,
                            input logic [15:0] o, input logic [3:0] eg);
        chk({tag, "_gnt"}, 32'(g), 32'(eg));
        chk({tag, "_vld"}, 32'(v), 32'(eg != 4'd0));
        if (eg != 4'd0) begin
            chk({tag, "_data"}, 32'(o), 32'(prev_in));
            chk({tag, "_fresh"}, 32'(o > last_del[id]), 32'd1);
            last_del[id] = o;
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        prev_in = rand_in;
        rand_in = rand_in + 16'd1;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rand_in = 16'hA000;
        prev_in = 16'h0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        req_a = 4'd0; req_b = 4'd0; req_c = 4'd0;
        for (int i = 0; i < 3; i++) last_del[i] = 16'd0;
        for (int j = 0; j < 4; j++) wt[j] = 0;
        rot = '{4'd1, 4'd1, 4'd0, 4'd2, 4'd2, 4'd0, 4'd4, 4'd4, 4'd0, 4'd8, 4'd8, 4'd0, 4'd1};
        repeat (3) nxt();

        // Default warm-up: 64 discarded cycles, first grant the cycle after ready.
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        req_a = 4'b1111;
        for (int c = 0; c <= 65; c++) begin
            if (c > 0) nxt();
            chk("warm_rdy", 32'(rdy_a), 32'(c >= 64));
            chk_word("warm", 0, gnt_a, vld_a, rout_a, (c >= 65) ? 4'b0001 : 4'b0000);
        end
        req_a = 4'd0;

        // Short bursts, everyone requesting: strict rotation with one idle between grants.
        req_c = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            nxt();
            chk_word("rot", 2, gnt_c, vld_c, rout_c, rot[i]);
        end
        req_c = 4'd0;

        // Single requester held: 16 words, one idle, 16 more.
        req_b = 4'b0100;
        for (int i = 0; i < 16; i++) begin nxt(); chk_word("burst1", 1, gnt_b, vld_b, rout_b, 4'b0100); end
        nxt(); chk_word("burst_gap", 1, gnt_b, vld_b, rout_b, 4'b0000);
        for (int i = 0; i < 16; i++) begin nxt(); chk_word("burst2", 1, gnt_b, vld_b, rout_b, 4'b0100); end
        req_b = 4'd0;
        nxt(); chk_word("burst_end", 1, gnt_b, vld_b, rout_b, 4'b0000);

        // req[1] held for three sampled cycles yields exactly three words.
        req_b = 4'b0010;
        for (int i = 0; i < 3; i++) begin nxt(); chk_word("pulse", 1, gnt_b, vld_b, rout_b, 4'b0010); end
        req_b = 4'd0;
        nxt(); chk_word("pulse_rel", 1, gnt_b, vld_b, rout_b, 4'b0000);
        // Pointer now sits at 2, so index 0 wins over 1.
        req_b = 4'b0011;
        nxt(); chk_word("ptr_wrap", 1, gnt_b, vld_b, rout_b, 4'b0001);
        req_b = 4'd0;
        nxt(); chk_word("ptr_rel", 1, gnt_b, vld_b, rout_b, 4'b0000);

        // Reset after the fifth word aborts the grant and restarts warm-up.
        req_b = 4'b1111;
        for (int i = 0; i < 5; i++) begin nxt(); chk_word("pre_rst", 1, gnt_b, vld_b, rout_b, 4'b0010); end
        rst_b = 1'b0;
        nxt();
        chk_word("rst_abort", 1, gnt_b, vld_b, rout_b, 4'b0000);
        chk("rst_rdy", 32'(rdy_b), 32'd0);
        rst_b = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) nxt();
            chk("rewarm_rdy", 32'(rdy_b), 32'(c >= 4));
            chk_word("rewarm", 1, gnt_b, vld_b, rout_b, (c >= 5) ? 4'b0001 : 4'b0000);
        end
        req_b = 4'd0;
        nxt(); chk_word("rewarm_rel", 1, gnt_b, vld_b, rout_b, 4'b0000);

        // Random traffic: requests stay up until served, then may drop.
        for (int n = 0; n < 10000; n++) begin
            nxt();
            chk("rnd_onehot", 32'($onehot0(gnt_b)), 32'd1);
            if (vld_b) begin
                chk("rnd_vgnt", 32'(|(gnt_b & req_b)), 32'd1);
                chk("rnd_data", 32'(rout_b), 32'(prev_in));
            end
            for (int j = 0; j < 4; j++) begin
                if (req_b[j] && !gnt_b[j]) wt[j]++;
                else wt[j] = 0;
                chk("rnd_starve", 32'(wt[j] <= STARVE), 32'd1);
            end
            nreq = req_b;
            for (int j = 0; j < 4; j++) begin
                if (!req_b[j]) begin
                    if ($urandom_range(3) == 0) nreq[j] = 1'b1;
                end else if (gnt_b[j] && vld_b && $urandom_range(7) == 0) begin
                    nreq[j] = 1'b0;
                end
            end
            req_b = nreq;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
